// File: rtl/ckg_ctrl_pkg.sv
// ckg_ctrl_pkg -- shared types and constants for the clock-gate controller.
//   ckg_state_t  : controller state (ON / IDLE / OFF / WAKE)
//   WAKE_CYC_DEF : default number of settle cycles after re-enabling the clock
//   STAT_W       : width of the gated-cycle statistics counter
package ckg_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_ON   = 2'd0,
    ST_IDLE = 2'd1,
    ST_OFF  = 2'd2,
    ST_WAKE = 2'd3
  } ckg_state_t;

  localparam int WAKE_CYC_DEF = 2;
  localparam int STAT_W       = 16;

endpackage

// File: rtl/ckg_stat_cnt.sv
// ckg_stat_cnt -- saturating event counter.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : zero the count; wins over inc
//   inc      : count one event on this edge
//   cnt      : current count, sticks at all-ones
module ckg_stat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ckg_ctrl.sv
// ckg_ctrl -- idle-driven clock-gate controller for one gated domain.
// Watches req/busy; after idle_thr consecutive idle cycles it drops cg_en,
// and on renewed activity it raises cg_en and waits WAKE_CYC settle cycles
// before reporting rdy again.
// Ports:
//   clk, rst   : ungated clock, synchronous active-high reset
//   req, busy  : activity request / gated domain still working
//   idle_thr   : idle cycles before gating (0 = never gate)
//   test_en    : scan enable, passed straight to cg_te
//   cg_en      : registered enable for the ICG cell E pin
//   cg_te      : test enable for the ICG cell TE pin
//   rdy        : registered, gated clock running and settled
//   stat_clr   : clear the gated-cycle counter
//   stat_cnt   : number of edges seen with cg_en low
//   dbg_state  : current controller state (ckg_state_t encoding)
// Optional feature: define CKG_CTRL_STAT_EN to build the statistics counter;
// otherwise stat_cnt is tied to zero and stat_clr is ignored.
// Handshake: the client holds req high until it samples rdy high; a transfer
// happens on any cycle where req and rdy are both high.
module ckg_ctrl
  import ckg_ctrl_pkg::*;
#(
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = WAKE_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              busy,
  input  logic [IDLE_W-1:0] idle_thr,
  input  logic              test_en,
  output logic              cg_en,
  output logic              cg_te,
  output logic              rdy,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_cnt,
  output logic [1:0]        dbg_state
);

  localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYC - 1);

  ckg_state_t        state;
  logic [IDLE_W-1:0] cnt;
  logic [3:0]        wake_cnt;

  logic              is_idle;
  logic              thr_zero;
  logic              thr_one;
  logic [IDLE_W:0]   cnt_inc;
  logic              cnt_hit;
  logic [IDLE_W-1:0] cnt_sat_next;

  assign is_idle  = !req && !busy;
  assign thr_zero = (idle_thr == '0);
  assign thr_one  = (idle_thr == IDLE_W'(1));
  // One extra bit so cnt+1 cannot wrap before comparing to the live threshold.
  assign cnt_inc      = {1'b0, cnt} + 1'b1;
  assign cnt_hit      = (cnt_inc >= {1'b0, idle_thr});
  assign cnt_sat_next = (&cnt) ? cnt : cnt + 1'b1;

  assign cg_te     = test_en;
  assign dbg_state = state;

  // cg_en and rdy are registered alongside the state so the enable changes on
  // exactly the edge that samples the gating / waking condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_ON;
      cg_en    <= 1'b1;
      rdy      <= 1'b1;
      cnt      <= '0;
      wake_cnt <= '0;
    end else begin
      case (state)
        ST_ON: begin
          if (is_idle && !thr_zero) begin
            if (thr_one) begin
              state <= ST_OFF;
              cg_en <= 1'b0;
              rdy   <= 1'b0;
              cnt   <= '0;
            end else begin
              state <= ST_IDLE;
              cnt   <= IDLE_W'(1);
            end
          end
        end
        ST_IDLE: begin
          if (thr_zero || !is_idle) begin
            state <= ST_ON;
            cnt   <= '0;
          end else if (cnt_hit) begin
            state <= ST_OFF;
            cg_en <= 1'b0;
            rdy   <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt_sat_next;
          end
        end
        ST_OFF: begin
          if (req || busy) begin
            state    <= ST_WAKE;
            cg_en    <= 1'b1;
            wake_cnt <= '0;
          end
        end
        ST_WAKE: begin
          // Activity inputs are ignored here; only the settle time matters.
          if (wake_cnt == WAKE_LAST) begin
            state    <= ST_ON;
            rdy      <= 1'b1;
            wake_cnt <= '0;
          end else begin
            wake_cnt <= wake_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_ON;
          cg_en <= 1'b1;
          rdy   <= 1'b1;
        end
      endcase
    end
  end

`ifdef CKG_CTRL_STAT_EN
  ckg_stat_cnt #(
    .W(STAT_W)
  ) u_stat (
    .clk (clk),
    .rst (rst),
    .clr (stat_clr),
    .inc (!cg_en),
    .cnt (stat_cnt)
  );
`else
  logic stat_clr_unused;
  assign stat_clr_unused = stat_clr;
  assign stat_cnt        = '0;
`endif

endmodule
